// File: rtl/regs_scan_if.sv
// Output stream of the register scanner: one {index, data} word per
// valid/ready handshake.
//
// Handshake: the master raises valid together with index/data and
// keeps all three stable until it sees ready at a rising edge while valid
// is high. That edge is the transfer. ready while valid is low has no
// effect, and the slave may drive ready without waiting for valid.
interface regs_scan_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] index;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output index,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  index,
    input  data,
    output ready
  );
endinterface

// File: rtl/regs_scan.sv
// Sequential read-out engine for the CPU register file. It owns one
// register-file read port. On start it walks first_reg..last_reg
// (inclusive) and reads one register per READ cycle. Each value is held
// as a snapshot and streamed as an {index, data} word over out_if.
module regs_scan #(
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_read_reg,
  output logic              rf_read_en,
  input  logic [DATA_W-1:0] rf_read_data,
  regs_scan_if.master       out_if,
  output logic [1:0]        state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Highest legal index. The scan stops here even if last_reg is larger,
  // so cur never wraps.
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_COUNT - 1);

  logic [1:0]        state_q,  state_d;
  logic [ADDR_W-1:0] cur_q,    cur_d;
  logic [ADDR_W-1:0] last_q,   last_d;
  logic [ADDR_W-1:0] rd_reg_q, rd_reg_d;
  logic              valid_q,  valid_d;
  logic [ADDR_W-1:0] index_q,  index_d;
  logic [DATA_W-1:0] data_q,   data_d;

  logic handshake;
  logic at_end;

  assign handshake = valid_q & out_if.ready;
  assign at_end    = (cur_q == last_q) || (cur_q == LAST_IDX);

  // Next-state and datapath decisions for the scan FSM.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    last_d   = last_q;
    rd_reg_d = rd_reg_q;
    valid_d  = valid_q;
    index_d  = index_q;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d  = first_reg;
          last_d = last_reg;
          if (first_reg <= last_reg) begin
            // The read address is registered ahead of READ, so the file
            // sees it in the same cycle that rf_read_en rises.
            rd_reg_d = first_reg;
            state_d  = S_READ;
          end else begin
            // Empty range: finish without emitting any word.
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        // The file answers combinationally. Capturing here makes the held
        // word immune to later writes to the same register.
        data_d  = rf_read_data;
        index_d = cur_q;
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (handshake) begin
          valid_d = 1'b0;
          if (at_end) begin
            state_d = S_DONE;
          end else begin
            cur_d    = cur_q + 1'b1;
            rd_reg_d = cur_q + 1'b1;
            state_d  = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset drops any in-flight word at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      last_q   <= '0;
      rd_reg_q <= '0;
      valid_q  <= 1'b0;
      index_q  <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      rd_reg_q <= rd_reg_d;
      valid_q  <= valid_d;
      index_q  <= index_d;
      data_q   <= data_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign rf_read_en  = (state_q == S_READ);
  assign rf_read_reg = rd_reg_q;
  assign state_o     = state_q;

  assign out_if.valid = valid_q;
  assign out_if.index = index_q;
  assign out_if.data  = data_q;

endmodule

// File: tb/tb_regs_scan.sv
// Directed bench for regs_scan. A behavioural register file answers the
// read port, a table of scans is applied in a loop, and a few hand-written
// sequences cover the snapshot and mid-scan reset corners.
module tb_regs_scan;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int W      = ADDR_W + DATA_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rf_read_reg;
  logic              rf_read_en;
  logic [DATA_W-1:0] rf_read_data;
  logic [1:0]        state_o;

  logic [DATA_W-1:0] rf_mem [32];

  regs_scan_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) out_if ();

  regs_scan #(.REG_COUNT(32), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .first_reg    (first_reg),
    .last_reg     (last_reg),
    .busy         (busy),
    .done         (done),
    .rf_read_reg  (rf_read_reg),
    .rf_read_en   (rf_read_en),
    .rf_read_data (rf_read_data),
    .out_if       (out_if),
    .state_o      (state_o)
  );

  assign rf_read_data = rf_mem[rf_read_reg];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus table ----------------
  // mode 0: out_ready held at 1; mode 1: ready 0,0,1 for each word.
  typedef struct {
    logic [4:0] first;
    logic [4:0] last;
    int         mode;
    int         exp_words;
    int         exp_done;   // cycle of done, counted from the start edge
    int         restart_k;  // cycle to pulse a second start, 0 = none
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  // Runs one scan and checks the word stream, done timing, busy length,
  // read count and output stability under backpressure.
  task automatic run_scan(input logic [4:0] f, input logic [4:0] l, input int mode,
                          input int exp_words, input int exp_done, input int restart_k);
    int busy_n, done_n, done_k, reads_n, words_n, stall_cnt, stable_err;
    logic have_prev;
    logic [W-1:0] prev_word, cur_word, exp_word;
    busy_n = 0; done_n = 0; done_k = -1; reads_n = 0; words_n = 0;
    stall_cnt = 0; stable_err = 0; have_prev = 1'b0; prev_word = '0;
    exp_q.delete();
    if (f <= l) begin
      for (int i = int'(f); i <= int'(l); i++) exp_q.push_back({5'(i), rf_mem[i]});
    end
    @(negedge clk);
    start = 1'b1; first_reg = f; last_reg = l; out_if.ready = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    first_reg = 5'($urandom_range(0, 31));
    last_reg  = 5'($urandom_range(0, 31));
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (rf_read_en) reads_n++;
      if (restart_k == k) begin
        start = 1'b1;
        first_reg = 5'd3;
        last_reg  = 5'd4;
      end else begin
        start = 1'b0;
      end
      if (out_if.valid) begin
        cur_word = {out_if.index, out_if.data};
        if (have_prev && cur_word !== prev_word) stable_err++;
        if (mode == 0) out_if.ready = 1'b1;
        else begin
          out_if.ready = (stall_cnt >= 2);
          stall_cnt++;
        end
        if (out_if.ready) begin
          words_n++;
          if (exp_q.size() == 0) begin
            chk("extra_word", {27'd0, cur_word}, 64'd0);
          end else begin
            exp_word = exp_q.pop_front();
            chk("word", {27'd0, cur_word}, {27'd0, exp_word});
          end
          stall_cnt = 0;
          have_prev = 1'b0;
        end else begin
          have_prev = 1'b1;
          prev_word = cur_word;
        end
      end else begin
        have_prev = 1'b0;
        out_if.ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (done_k >= 0 && k >= done_k + 2) break;
    end
    start = 1'b0;
    out_if.ready = 1'b0;
    if (done_k < 0) begin
      errors++;
      $display("FAIL scan_timeout: no done for scan %0d..%0d", f, l);
    end
    chk("done_cycle", 64'(done_k), 64'(exp_done));
    chk("done_pulses", 64'(done_n), 64'd1);
    chk("busy_cycles", 64'(busy_n), 64'(exp_done));
    chk("word_count", 64'(words_n), 64'(exp_words));
    chk("read_count", 64'(reads_n), 64'(exp_words));
    chk("words_left", 64'(exp_q.size()), 64'd0);
    chk("stable", 64'(stable_err), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic found;
    rst_n = 1'b0; start = 1'b0; first_reg = '0; last_reg = '0; out_if.ready = 1'b0;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'(i) * 32'h01010101;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_en", 64'(rf_read_en), 64'd0);
    chk("rst_rd_reg", 64'(rf_read_reg), 64'd0);
    chk("rst_valid", 64'(out_if.valid), 64'd0);
    chk("rst_index", 64'(out_if.index), 64'd0);
    chk("rst_data", 64'(out_if.data), 64'd0);
    chk("rst_state", 64'(state_o), 64'd0);

    // first, last, mode, words, done cycle, restart cycle
    vecs[0] = '{5'd0,  5'd31, 0, 32, 65, 0};
    vecs[1] = '{5'd4,  5'd6,  1, 3,  13, 0};
    vecs[2] = '{5'd7,  5'd7,  0, 1,  3,  0};
    vecs[3] = '{5'd9,  5'd3,  0, 0,  1,  0};
    vecs[4] = '{5'd0,  5'd31, 0, 32, 65, 10};
    vecs[5] = '{5'd31, 5'd31, 0, 1,  3,  0};
    vecs[6] = '{5'd30, 5'd31, 1, 2,  9,  0};
    vecs[7] = '{5'd0,  5'd0,  1, 1,  5,  0};

    for (int v = 0; v < NVEC; v++) begin
      run_scan(vecs[v].first, vecs[v].last, vecs[v].mode,
               vecs[v].exp_words, vecs[v].exp_done, vecs[v].restart_k);
    end

    // Snapshot: overwrite reg 5 while its word is held in SEND
    rf_mem[5] = 32'h5;
    @(negedge clk);
    start = 1'b1; first_reg = 5'd5; last_reg = 5'd5; out_if.ready = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("snap_rd_en", 64'(rf_read_en), 64'd1);
    chk("snap_rd_reg", 64'(rf_read_reg), 64'd5);
    @(negedge clk);
    chk("snap_valid", 64'(out_if.valid), 64'd1);
    chk("snap_data0", 64'(out_if.data), 64'h5);
    rf_mem[5] = 32'hDEADBEEF;
    repeat (3) begin
      @(negedge clk);
      chk("snap_hold_valid", 64'(out_if.valid), 64'd1);
      chk("snap_hold_index", 64'(out_if.index), 64'd5);
      chk("snap_hold_data", 64'(out_if.data), 64'h5);
    end
    out_if.ready = 1'b1;
    @(negedge clk);
    chk("snap_done", 64'(done), 64'd1);
    chk("snap_valid_off", 64'(out_if.valid), 64'd0);
    out_if.ready = 1'b0;
    @(negedge clk);
    chk("snap_idle", 64'(busy), 64'd0);
    rf_mem[5] = 32'h05050505;

    // Reset while SEND holds index 10
    found = 1'b0;
    @(negedge clk);
    start = 1'b1; first_reg = 5'd8; last_reg = 5'd12; out_if.ready = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_if.valid && out_if.index == 5'd10) begin
        found = 1'b1;
        break;
      end
      out_if.ready = 1'b1;
    end
    out_if.ready = 1'b0;
    chk("mid_found_idx10", 64'(found), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_valid", 64'(out_if.valid), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_index", 64'(out_if.index), 64'd0);
    chk("mid_data", 64'(out_if.data), 64'd0);
    chk("mid_rd_reg", 64'(rf_read_reg), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_after_done", 64'(done), 64'd0);
    chk("mid_after_busy", 64'(busy), 64'd0);
    run_scan(5'd8, 5'd12, 0, 5, 11, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regs_scan.md
# regs_scan

Sequential read-out engine for the 32x32 CPU register file. On a start pulse it walks a register range through one register-file read port, captures each value, and streams `{index, data}` words to a downstream consumer (debug display, UART dumper, test harness) over a valid/ready handshake. It sits beside the register file and owns read port 1 (`read_reg1` / `read_en1` / `read_data1_o`) while busy.

## Interface
- `REG_COUNT`, 32, number of registers in the file.
- `ADDR_W`, 5, register index width.
- `DATA_W`, 32, register data width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request to begin a scan; ignored while `busy`=1.
- `first_reg`  in  ADDR_W  first index of the scan; sampled with `start`.
- `last_reg`  in  ADDR_W  last index of the scan, inclusive; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`, inclusive.
- `done`  out  1  one-cycle pulse when the scan ends.
- `rf_read_reg`  out  ADDR_W  register index to the file's read port.
- `rf_read_en`  out  1  read enable to the file's read port.
- `rf_read_data`  in  DATA_W  data returned by the file; valid in the same cycle as the address.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_index`  out  ADDR_W  index of the register held on `out_data`.
- `out_data`  out  DATA_W  captured register value.

## Operation
- FSM states: IDLE, READ, SEND, DONE.
- **IDLE:** `busy`=0, `rf_read_en`=0.
  - On `start`, latch `first_reg`/`last_reg` and load `cur`=`first_reg`.
  - If `first_reg` <= `last_reg` (unsigned), go to READ; otherwise go to DONE (empty scan: no words emitted).
- **READ (one cycle):** drive `rf_read_reg`=`cur` and `rf_read_en`=1.
  - At the clock edge, capture `rf_read_data` into `out_data` and `cur` into `out_index`, set `out_valid`=1, and go to SEND.
- **SEND:** hold `out_valid`, `out_index` and `out_data` stable until `out_valid`&`out_ready` (the handshake).
  - On the handshake, clear `out_valid`.
  - If `cur`==`last_reg`, go to DONE; otherwise `cur`=`cur`+1 and go to READ.
- **DONE (one cycle):** `done`=1 and `busy`=1, then return to IDLE.
- `cur` never wraps. A scan ending at index 31 ends on the compare, with no increment past 31.
- Captured data is a snapshot. Register writes after the READ cycle do not change the held `out_data`.
- `rf_read_en` is high only in READ. `rf_read_reg` holds its last value at all other times.
- `start` asserted while `busy`=1 is ignored and is not queued.
- `first_reg`/`last_reg` changes after the `start` cycle have no effect on the running scan.

## Timing
- Reset values:
  - state=IDLE, `cur`=0.
  - `busy`=0, `done`=0, `rf_read_en`=0, `rf_read_reg`=0.
  - `out_valid`=0, `out_index`=0, `out_data`=0.
- `start` sampled at edge t:
  - READ occupies cycle t+1.
  - `out_valid`=1 from t+2.
- Throughput with `out_ready` held at 1: one word per 2 cycles.
  - An N-word scan shows `done` at cycle t+2N+1.
  - Full scan 0..31: `done` at t+65.
- Backpressure: each cycle with `out_ready`=0 in SEND adds one cycle. Outputs stay stable throughout.
- `out_ready` while `out_valid`=0 has no effect.
- Reset asserted mid-scan: at the next edge, all outputs take their reset values. No `done` pulse, and the partial word is dropped.

## Test plan
- Full scan, no backpressure:
  - Stimulus: preload reg[i]=i*32'h01010101, `first_reg`=0, `last_reg`=31, `out_ready`=1, pulse `start`.
  - Required: 32 handshakes with `out_index` 0..31 and matching data, `busy` high for 65 cycles, a single `done` pulse at t+65.
- Backpressure:
  - Stimulus: scan 4..6 with `out_ready` toggling 0,0,1.
  - Required: each word held stable across the stall cycles, words in order 4,5,6, `done` only after the handshake on index 6.
- Single-register and empty scans:
  - Stimulus: `first_reg`=`last_reg`=7.
  - Required: exactly one word (index 7), `done` at t+3.
  - Stimulus: `first_reg`=9, `last_reg`=3.
  - Required: no `out_valid`, `rf_read_en` never high, `done` at t+1.
- Snapshot:
  - Stimulus: write reg[5]=32'hDEADBEEF during SEND of index 5, with reg[5] previously 32'h5.
  - Required: `out_data`=32'h5 until the handshake.
- Start while busy and reset mid-scan:
  - Stimulus: second `start` during a 0..31 scan.
  - Required: ignored; still exactly 32 words.
  - Stimulus: `rst_n`=0 while SEND holds index 10.
  - Required: next edge gives `out_valid`=0 and `busy`=0 with no `done`; a new `start` then scans from `first_reg` correctly.
